// File: rtl/aidc_lite_decomp_dispatch.sv
// aidc_lite_decomp_dispatch: routes stream packets to one decoder channel and merges its buffer writes
module aidc_lite_decomp_dispatch #(
  parameter int NUM_DEC = 3,
  parameter int DATA_W  = 32,
  parameter int BUF_AW  = 4,
  parameter int BUF_DW  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  input  logic                      in_sop_i,
  input  logic                      in_eop_i,
  input  logic [DATA_W-1:0]         in_data_i,
  output logic                      in_ready_o,
  output logic [NUM_DEC-1:0]        dec_valid_o,
  output logic                      dec_sop_o,
  output logic                      dec_eop_o,
  output logic [DATA_W-1:0]         dec_data_o,
  input  logic [NUM_DEC-1:0]        dec_wren_i,
  input  logic [NUM_DEC*BUF_AW-1:0] dec_waddr_i,
  input  logic [NUM_DEC*BUF_DW-1:0] dec_wdata_i,
  input  logic [NUM_DEC-1:0]        dec_done_i,
  output logic                      buf_wren_o,
  output logic [BUF_AW-1:0]         buf_waddr_o,
  output logic [BUF_DW-1:0]         buf_wdata_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic [15:0]               pkt_len_o,
  output logic                      err_o,
  output logic [1:0]                err_code_o
);
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_DONE} state_t;
  state_t state;
  logic [SEL_W-1:0] sel, new_sel, fsel;
  logic [15:0] cnt, cnt_nxt, wcnt;
  logic acc, sop_acc, bad, fwd, active, own_wr, hit, tmo, stray;
  assign busy_o     = state != IDLE;
  assign in_ready_o = state != WAIT_DONE;
  assign acc        = in_valid_i & in_ready_o;
  assign new_sel    = in_data_i[DATA_W-1 -: SEL_W];
  assign bad        = int'(new_sel) >= NUM_DEC;
  assign sop_acc    = acc & in_sop_i & (state == IDLE | state == STREAM);
  assign fwd        = sop_acc ? !bad : acc & state == STREAM;
  assign fsel       = sop_acc ? new_sel : sel;
  assign cnt_nxt    = sop_acc ? 16'd1 : cnt + 16'(cnt != 16'hFFFF);
  assign active     = state == STREAM | state == WAIT_DONE;
  assign own_wr     = active & dec_wren_i[sel];
  // Only the owning channel may write, and only while a packet is in flight
  assign stray      = |(active ? dec_wren_i & ~(NUM_DEC'(1) << sel) : dec_wren_i);
  assign hit        = state == WAIT_DONE & dec_done_i[sel];
  assign tmo        = state == WAIT_DONE & !hit & wcnt == 16'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      wcnt        <= '0;
      dec_valid_o <= '0;
      dec_sop_o   <= 1'b0;
      dec_eop_o   <= 1'b0;
      dec_data_o  <= '0;
      buf_wren_o  <= 1'b0;
      buf_waddr_o <= '0;
      buf_wdata_o <= '0;
      done_o      <= 1'b0;
      pkt_len_o   <= '0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
    end else begin
      dec_valid_o <= fwd ? NUM_DEC'(1) << fsel : '0;
      if (fwd) {dec_sop_o, dec_eop_o, dec_data_o} <= {in_sop_i, in_eop_i, in_data_i};
      if (fwd) cnt <= cnt_nxt;
      if (fwd & in_eop_i) pkt_len_o <= cnt_nxt;
      if (sop_acc & !bad) sel <= new_sel;
      buf_wren_o  <= own_wr;
      buf_waddr_o <= own_wr ? dec_waddr_i[sel*BUF_AW +: BUF_AW] : '0;
      buf_wdata_o <= own_wr ? dec_wdata_i[sel*BUF_DW +: BUF_DW] : '0;
      done_o      <= hit;
      err_o       <= tmo | (sop_acc & bad) | stray;
      err_code_o  <= tmo ? 2'd2 : (sop_acc & bad) ? 2'd1 : stray ? 2'd3 : 2'd0;
      wcnt        <= state == WAIT_DONE ? wcnt + 16'd1 : '0;
      if (sop_acc & bad) state <= in_eop_i ? IDLE : DRAIN;
      else if (fwd) state <= in_eop_i ? WAIT_DONE : STREAM;
      else if (state == DRAIN & acc & in_eop_i) state <= IDLE;
      else if (hit | tmo) state <= IDLE;
    end
  end
endmodule

// File: doc/aidc_lite_decomp_dispatch.md
AIDC_LITE_DECOMP_DISPATCH -- requirements
Module: aidc_lite_decomp_dispatch

Interface
REQ-001 SHALL have parameter NUM_DEC, default 3, number of decoder channels (2..4).
REQ-002 SHALL have parameter DATA_W, default 32, stream word width.
REQ-003 SHALL have parameter BUF_AW, default 4, buffer address width.
REQ-004 SHALL have parameter BUF_DW, default 64, buffer data width.
REQ-005 SHALL have parameter TIMEOUT, default 256, max cycles waiting for decoder done.
REQ-006 SHALL have SEL_W = 2, the width of the channel-select field.
REQ-007 SHALL run on one clock; reset is asynchronous and active-low.
REQ-008 Ports (name  direction  width  meaning):
 clk  in  1  clock;
 rst_n  in  1  async active-low reset;
 in_valid_i  in  1  stream word valid;
 in_sop_i  in  1  first word of packet;
 in_eop_i  in  1  last word of packet;
 in_data_i  in  DATA_W  stream word;
 in_ready_o  out  1  word accepted when valid&ready;
 dec_valid_o  out  NUM_DEC  one-hot word strobe to decoders;
 dec_sop_o  out  1  forwarded sop;
 dec_eop_o  out  1  forwarded eop;
 dec_data_o  out  DATA_W  forwarded word;
 dec_wren_i  in  NUM_DEC  per-decoder buffer write;
 dec_waddr_i  in  NUM_DEC*BUF_AW  packed write addresses;
 dec_wdata_i  in  NUM_DEC*BUF_DW  packed write data;
 dec_done_i  in  NUM_DEC  per-decoder done pulse;
 buf_wren_o  out  1  merged buffer write;
 buf_waddr_o  out  BUF_AW  merged address;
 buf_wdata_o  out  BUF_DW  merged data;
 done_o  out  1  packet complete pulse;
 busy_o  out  1  state != IDLE;
 pkt_len_o  out  16  word count of last packet;
 err_o  out  1  error pulse;
 err_code_o  out  2  1=BAD_SEL, 2=TIMEOUT, 3=STRAY_WR.

Function
REQ-009 FSM states SHALL be IDLE, STREAM, DRAIN, WAIT_DONE.
REQ-010 Channel select SHALL be in_data_i[DATA_W-1 -: SEL_W], latched on an accepted sop word.
REQ-011 in_ready_o SHALL be 1 in IDLE, STREAM and DRAIN, and 0 in WAIT_DONE.
REQ-012 IDLE, accepted non-sop word: drop it, no error.
REQ-013 IDLE, accepted sop, sel<NUM_DEC: forward the word, then go to STREAM (or to WAIT_DONE if eop is also set).
REQ-014 IDLE, accepted sop, sel>=NUM_DEC: err_o pulse with code 1, then go to DRAIN (or to IDLE if eop is also set); nothing is forwarded.
REQ-015 Forwarding SHALL be registered with 1-cycle latency; dec_valid_o[sel]=1 and all other bits 0; sop, eop and data are copied.
REQ-016 STREAM: forward every accepted word; go to WAIT_DONE on eop.
REQ-017 STREAM, accepted sop: err code 1 is NOT raised; the packet restarts with a new sel and pkt counter=1; a bad sel is handled as in REQ-014.
REQ-018 DRAIN: consume and discard words; go to IDLE on eop.
REQ-019 WAIT_DONE: on dec_done_i[sel], done_o pulses for 1 cycle the next cycle, then go to IDLE; done from other channels is ignored.
REQ-020 WAIT_DONE: a 16-bit counter clears on entry and increments each cycle; when it reaches TIMEOUT-1 without done: err code 2, no done_o, go to IDLE.
REQ-021 Word counter SHALL count forwarded words per packet, saturating at 16'hFFFF; pkt_len_o updates on the eop-forward cycle.
REQ-022 Buffer merge SHALL be registered (1 cycle): buf_wren_o=dec_wren_i[sel], with the matching address and data slices; outputs are 0 when not wren.
REQ-023 A dec_wren_i bit for a channel != sel, or any bit while in IDLE/DRAIN, SHALL be a stray write: the write is dropped and err code 3 is raised.
REQ-024 Simultaneous errors in one cycle SHALL report priority TIMEOUT > BAD_SEL > STRAY_WR; err_o is a single pulse.
REQ-025 A done that coincides with a timeout SHALL win: done_o is asserted, no error.
REQ-026 busy_o SHALL be combinational from state.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and set all outputs to 0 (except in_ready_o=1), with sel=0 and all counters=0.
REQ-028 Reset mid-packet SHALL abandon the packet; after release, non-sop words are dropped per REQ-012.

Verification
REQ-029 sop word 0x4000_0000 + 3 words + eop, then dec_done_i=3'b010 -> dec_valid_o=3'b010 for 4 cycles, pkt_len_o=4, done_o 1 cycle after done.
REQ-030 sop with data[31:30]=2'b11 (NUM_DEC=3) and 2 words to eop -> err_code_o=1, no dec_valid_o, then IDLE.
REQ-031 TIMEOUT=8, eop then no done -> err_code_o=2 exactly 8 cycles after entering WAIT_DONE; in_ready_o=0 throughout.
REQ-032 sel=0, dec_wren_i=3'b101 with addr 5 / data 0xAA -> buf_wren_o=1, buf_waddr_o=5, buf_wdata_o=0xAA; err_code_o=3 for channel 2.
REQ-033 rst_n pulsed low mid-STREAM -> busy_o=0 the same cycle; a following non-sop word produces no dec_valid_o.
REQ-034 Single-word packet (sop&eop) -> WAIT_DONE directly, pkt_len_o=1.
